mem_port_arbiter: RTL and testbench

Shares the single-port unified instruction/data memory between the core's instruction-fetch stage and its load/store stage. Each requester uses a request/ready handshake, and the memory side uses a request/acknowledge handshake with variable latency. Data accesses normally win arbitration, and a starvation counter guarantees fetch progress. The block sits between the pipeline's IF/MEM stages and the memory model inside `single_cycle_top`'s successor pipeline top.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_prio_sel.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_t    : arbiter FSM state encoding
//   GNT_I / GNT_D  : grant-select values (fetch / data)
//   STARVE_MAX_DEF : default number of data grants allowed while a fetch waits
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_prio_sel.sv
// Priority select for the memory port arbiter.
// Data wins unless a fetch has already waited through STARVE_MAX data grants.
// Ports:
//   if_req, dm_req : pending requests
//   starve_cnt     : current starvation count
//   gnt_vld        : at least one request is pending
//   gnt_sel        : GNT_I or GNT_D
//   starve_nxt     : starvation count to load when the arbiter is idle
module arb_prio_sel
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       if_req,
  input  logic       dm_req,
  input  logic [3:0] starve_cnt,
  output logic       gnt_vld,
  output logic       gnt_sel,
  output logic [3:0] starve_nxt
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  always_comb begin
    gnt_vld    = if_req | dm_req;
    gnt_sel    = GNT_I;
    starve_nxt = starve_cnt;

    if (dm_req && ((starve_cnt < SMAX) || !if_req))
      gnt_sel = GNT_D;

    // No waiting fetch means nothing is being starved.
    if (!if_req)
      starve_nxt = 4'd0;
    else if (gnt_sel == GNT_D)
      starve_nxt = (starve_cnt >= SMAX) ? SMAX : starve_cnt + 4'd1;
    else
      starve_nxt = 4'd0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// load/store. Requesters use req/ready, the memory side uses req/ack with
// variable latency.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   if_req/if_addr                  : fetch request, held until if_ready
//   if_ready/if_rdata               : one-cycle completion pulse, fetched word
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be : data request, held until dm_ready
//   dm_ready/dm_rdata               : one-cycle completion pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : registered memory transaction
//   mem_ack/mem_rdata               : memory completion and read data
//
// state  | meaning
// IDLE   | arbitrate between pending requests
// BUSY_I | fetch transaction outstanding on the memory port
// BUSY_D | load/store transaction outstanding on the memory port
// RESP_I | if_ready pulse
// RESP_D | dm_ready pulse
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_ready,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_t state;
  logic [3:0] starve_cnt;
  logic       gnt_vld;
  logic       gnt_sel;
  logic [3:0] starve_nxt;

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .starve_cnt (starve_cnt),
    .gnt_vld    (gnt_vld),
    .gnt_sel    (gnt_sel),
    .starve_nxt (starve_nxt)
  );

  // Ready pulses are decoded from state so a reset clears them at once.
  assign if_ready = (state == RESP_I);
  assign dm_ready = (state == RESP_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          starve_cnt <= starve_nxt;
          if (gnt_vld) begin
            mem_req <= 1'b1;
            if (gnt_sel == GNT_D) begin
              state     <= BUSY_D;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_be    <= dm_be;
            end else begin
              state     <= BUSY_I;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= '0;
            end
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            state    <= RESP_I;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            // Stores leave the previous load data in place.
            if (!mem_we)
              dm_rdata <= mem_rdata;
            state <= RESP_D;
          end
        end
        RESP_I, RESP_D: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_ready  (dm_ready),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Memory contents as a fixed function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hDEADBEEF;
  endfunction

  // Transaction-level reference state
  bit          outst, out_d, out_we;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_be;
  int          grant_cyc, lat, ack_cyc, idle_from, first_req, streak, mode;
  bit          if_wait, dm_wait, if_low_seen, smp_if, smp_dm, log_on;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  bit          grant_log[$];

  task automatic model_reset();
    outst = 0; out_d = 0; out_we = 0;
    out_addr = 0; out_wdata = 0; out_be = 0;
    grant_cyc = 0; lat = 0; ack_cyc = -1;
    idle_from = cyc + 1; first_req = -1; streak = 0;
    if_wait = 0; dm_wait = 0; if_low_seen = 0; smp_if = 0; smp_dm = 0;
    exp_if_rdata = 0; exp_dm_rdata = 0;
  endtask

  function automatic bit want_raise();
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 2) == 0);
  endfunction

  task automatic step();
    bit exp_ir, exp_dr, win_d;
    @(negedge clk);
    cyc++;

    exp_ir = outst && (ack_cyc == cyc - 1) && !out_d;
    exp_dr = outst && (ack_cyc == cyc - 1) && out_d;
    chk("if_ready", if_ready, exp_ir);
    chk("dm_ready", dm_ready, exp_dr);
    if (exp_ir) exp_if_rdata = memf(out_addr);
    if (exp_dr && !out_we) exp_dm_rdata = memf(out_addr);
    if (exp_ir || exp_dr) begin
      outst = 0;
      if (out_d) dm_wait = 0; else if_wait = 0;
      idle_from = cyc + 1; first_req = -1; if_low_seen = 0; ack_cyc = -1;
    end
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("dm_rdata", dm_rdata, exp_dm_rdata);

    // A request seen in an idle cycle must be on the memory port one cycle later.
    if (!outst && first_req >= 0 && cyc == first_req + 1) begin
      if (if_low_seen) streak = 0;
      win_d = smp_dm && (streak < SMAX || !smp_if);
      if (win_d) streak = smp_if ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
      else streak = 0;
      outst = 1; out_d = win_d; grant_cyc = cyc; ack_cyc = -1;
      lat = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 3));
      if (win_d) begin
        out_we = dm_we; out_addr = dm_addr; out_wdata = dm_wdata; out_be = dm_be;
      end else begin
        out_we = 0; out_addr = if_addr; out_wdata = 0; out_be = 0;
      end
      if (log_on) grant_log.push_back(win_d);
    end

    if (outst && ack_cyc < 0) begin
      chk("mem_req", mem_req, 1);
      chk("mem_we", mem_we, out_we);
      chk("mem_addr", mem_addr, out_addr);
      chk("mem_wdata", mem_wdata, out_wdata);
      chk("mem_be", mem_be, out_be);
    end else begin
      chk("mem_req_idle", mem_req, 0);
    end

    // Granted requester may withdraw while busy; the access must still complete.
    if (outst && ack_cyc < 0 && mode == 2 && $urandom_range(0, 7) == 0) begin
      if (out_d) dm_req = 0; else if_req = 0;
    end

    if (outst && ack_cyc < 0 && (cyc - grant_cyc) >= lat) begin
      mem_ack = 1; mem_rdata = memf(out_addr); ack_cyc = cyc;
    end else begin
      mem_ack   = !outst && ($urandom_range(0, 5) == 0);
      mem_rdata = $urandom;
    end

    if (!if_wait) begin
      if (want_raise()) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC; if_wait = 1;
      end else begin
        if_req = 0;
      end
    end
    if (!dm_wait) begin
      if (want_raise()) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom;
        dm_be = 4'($urandom_range(0, 15)); dm_wait = 1;
      end else begin
        dm_req = 0;
      end
    end

    if (!outst && cyc >= idle_from && first_req < 0) begin
      if (!if_req) if_low_seen = 1;
      if (if_req || dm_req) begin
        first_req = cyc; smp_if = if_req; smp_dm = dm_req;
      end
    end
  endtask

  task automatic run(input int m, input int n);
    mode = m;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_be = 0; mem_ack = 0; mem_rdata = 0; mode = 0; log_on = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    rst = 0;
    model_reset();

    run(2, 1500);
    run(0, 40);

    // Both requesters held continuously from a cleared starvation count.
    log_on = 1;
    run(1, 150);
    log_on = 0;
    chk("starve_grant_count", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10; i++)
      if (i < grant_log.size())
        chk($sformatf("starve_seq[%0d]", i), grant_log[i], (i % 5 == 4) ? 0 : 1);
    run(0, 40);
    run(2, 1000);
    run(0, 40);

    // Reset in the middle of a load.
    @(negedge clk);
    dm_req = 1; dm_we = 0; dm_addr = 32'h200; dm_wdata = 0; dm_be = 0; mem_ack = 0;
    @(negedge clk);
    chk("rstmid_mem_req_busy", mem_req, 1);
    chk("rstmid_mem_addr", mem_addr, 32'h200);
    @(negedge clk);
    rst = 1; dm_req = 0;
    #1;
    chk("rstmid_mem_req_async", mem_req, 0);
    chk("rstmid_dm_ready_async", dm_ready, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 0;
      chk("rstmid_dm_ready", dm_ready, 0);
      chk("rstmid_if_ready", if_ready, 0);
      chk("rstmid_mem_req", mem_req, 0);
      chk("rstmid_dm_rdata", dm_rdata, 0);
      chk("rstmid_state", 32'(dut.state), 32'(IDLE));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
